// File: rtl/hdmi_video_timing_pkg.sv
// Shared types and helpers for the HDMI video timing generator.
package hdmi_pkg;

    // One pixel as carried on the stream: {R, G, B}.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Stream-alignment state: hunt for sop, wait for the raster top, play out.
    typedef enum logic [1:0] {
        SEEK,
        ARMED,
        RUN
    } fsm_e;

    // Total clocks per line (or lines per frame) from its four regions.
    function automatic int video_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Avalon-ST pixel stream into the timing generator (ready latency 0).
interface hdmi_video_timing_if;

    logic [23:0] snk_data;
    logic        snk_valid;
    logic        snk_sop;
    logic        snk_eop;
    logic        snk_ready;

    modport master (
        output snk_data, snk_valid, snk_sop, snk_eop,
        input  snk_ready
    );

    modport slave (
        input  snk_data, snk_valid, snk_sop, snk_eop,
        output snk_ready
    );

endinterface

// File: rtl/hdmi_raster_cnt.sv
// Free-running h/v raster counters with active, hsync and vsync decode.
// Line and frame order are both active, front porch, sync, back porch.
module hdmi_raster_cnt
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic clk,
    input  logic reset_n,
    output logic act,
    output logic hs,
    output logic vs,
    output logic first_px,
    output logic last_px,
    output logic frame_end
);

    localparam int H_TOTAL = video_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = video_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // Advance the raster; v_cnt steps on each line wrap, so vsync edges land at h_cnt==0.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Region decode of the current raster position.
    always_comb begin
        act       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs        = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs        = (v_cnt >= VS_START) && (v_cnt < VS_END);
        first_px  = (h_cnt == '0) && (v_cnt == '0);
        last_px   = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
        frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing generator that plays a framed Avalon-ST pixel stream into
// the TMDS encoders. Frames are locked to the raster via sop; any starved or
// misframed pixel blanks the rest of the frame and re-seeks sop.
module hdmi_video_timing
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hdmi_video_timing_if.slave    snk,
    output logic                  de,
    output logic [1:0]            vh,
    output logic [7:0]            red,
    output logic [7:0]            green,
    output logic [7:0]            blue,
    output logic                  underflow,
    output logic                  frame_start
);

    logic act, hs, vs, first_px, last_px, frame_end;

    hdmi_raster_cnt #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_raster (
        .clk       (clk),
        .reset_n   (reset_n),
        .act       (act),
        .hs        (hs),
        .vs        (vs),
        .first_px  (first_px),
        .last_px   (last_px),
        .frame_end (frame_end)
    );

    fsm_e state, state_d;
    logic en;
    rgb_t pix_q;
    logic pix_sop, pix_eop, pix_vld;
    logic drain, accept, bad, show;

    // Alignment state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SEEK;
        else          state <= state_d;
    end

    // Handshake, framing check and next state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d       = state;
        drain         = (state == RUN) && act;
        snk.snk_ready = en && (!pix_vld || drain);
        accept        = snk.snk_valid && snk.snk_ready;
        bad           = drain && (!pix_vld || (pix_sop != first_px) || (pix_eop != last_px));
        show          = drain && !bad;
        case (state)
            SEEK:    if (accept && snk.snk_sop) state_d = ARMED;
            ARMED:   if (frame_end)             state_d = RUN;
            RUN:     if (bad)                   state_d = SEEK;
            default:                            state_d = SEEK;
        endcase
    end

    // Keep snk_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) en <= 1'b0;
        else          en <= 1'b1;
    end

    // One-word holding register. On an error the word and any beat accepted
    // in the same cycle are dropped; SEEK then hunts for the next sop.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the data word is reset too, so a mid-frame reset leaves no stale pixel behind.
        if (!reset_n) begin
            pix_q   <= '0;
            pix_sop <= 1'b0;
            pix_eop <= 1'b0;
            pix_vld <= 1'b0;
        end else if (bad) begin
            pix_vld <= 1'b0;
        end else if (accept && (state != SEEK || snk.snk_sop)) begin
            pix_q   <= rgb_t'(snk.snk_data);
            pix_sop <= snk.snk_sop;
            pix_eop <= snk.snk_eop;
            pix_vld <= 1'b1;
        end else if (drain) begin
            pix_vld <= 1'b0;
        end
    end

    // Registered encoder-facing outputs, one clock behind the raster counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de          <= 1'b0;
            vh          <= {~VS_POL, ~HS_POL};
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            underflow   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            de          <= act;
            vh          <= {vs ? VS_POL : ~VS_POL, hs ? HS_POL : ~HS_POL};
            red         <= show ? pix_q.r : '0;
            green       <= show ? pix_q.g : '0;
            blue        <= show ? pix_q.b : '0;
            underflow   <= bad;
            frame_start <= show && first_px;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Randomized scoreboard bench for hdmi_video_timing on a tiny 8x5 raster.
module tb_hdmi_video_timing;

    localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 2, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    typedef struct {
        bit          gap;
        logic [23:0] data;
        bit          sop;
        bit          eop;
    } item_t;

    typedef struct {
        logic        de;
        logic [1:0]  vh;
        logic [23:0] rgb;
        logic        uf;
        logic        fs;
        logic        rdy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        de, underflow, frame_start;
    logic [1:0]  vh;
    logic [7:0]  red, green, blue;

    hdmi_video_timing_if ifc ();

    hdmi_video_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .HS_POL   (1'b1), .VS_POL (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .snk         (ifc),
        .de          (de),
        .vh          (vh),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .underflow   (underflow),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    item_t src[$];
    exp_t  exp_q[$];
    item_t hold[$];
    int    k = 0;
    int    phase = 0;
    bit    fresh = 1'b1;
    bit    presenting = 1'b0;
    bit    done = 1'b0;

    localparam int HUNT = 0, WAIT = 1, PLAY = 2;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Raster geometry from plain arithmetic on the cycle index since reset release.
    function automatic bit act_at(int kk);
        int p = kk % FRAME;
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    // Reference model: one step per clock edge, pushes the outputs expected after that edge.
    int    m_pos, m_x, m_y;
    bit    m_act, m_hs, m_vs, m_first, m_last, m_fend, m_play, m_rdy, m_acc, m_err;
    exp_t  m_e;
    item_t m_beat;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                exp_q.delete();
                hold.delete();
                phase = HUNT;
                k     = 0;
                fresh = 1'b1;
            end else begin
                m_pos   = k % FRAME;
                m_x     = m_pos % HT;
                m_y     = m_pos / HT;
                m_act   = act_at(k);
                m_hs    = (m_x >= HA + HF) && (m_x < HA + HF + HSW);
                m_vs    = (m_y >= VA + VF) && (m_y < VA + VF + VSW);
                m_first = (m_x == 0) && (m_y == 0);
                m_last  = (m_x == HA - 1) && (m_y == VA - 1);
                m_fend  = (m_x == HT - 1) && (m_y == VT - 1);
                m_play  = (phase == PLAY) && m_act;
                m_rdy   = (k > 0) && ((hold.size() == 0) || m_play);
                m_acc   = ifc.snk_valid && m_rdy;
                m_err   = m_play && ((hold.size() == 0) ||
                                     (hold[0].sop != m_first) || (hold[0].eop != m_last));
                m_e.de  = m_act;
                m_e.vh  = {m_vs, m_hs};
                m_e.rgb = (m_play && !m_err) ? hold[0].data : 24'h0;
                m_e.uf  = m_err;
                m_e.fs  = m_play && !m_err && m_first;
                m_beat  = '{gap: 1'b0, data: ifc.snk_data, sop: ifc.snk_sop, eop: ifc.snk_eop};
                if (m_err) begin
                    hold.delete();
                    phase = HUNT;
                end else if (phase == HUNT) begin
                    if (m_acc && m_beat.sop) begin
                        hold.push_back(m_beat);
                        phase = WAIT;
                    end
                end else if (phase == WAIT) begin
                    if (m_fend) phase = PLAY;
                end else begin
                    if (m_play) void'(hold.pop_front());
                    if (m_acc) hold.push_back(m_beat);
                end
                k++;
                m_e.rdy = (hold.size() == 0) || ((phase == PLAY) && act_at(k));
                exp_q.push_back(m_e);
                fresh = 1'b0;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the scoreboard queue.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n || fresh) begin
                check("rst_de",    32'(de),            32'(0));
                check("rst_vh",    32'(vh),            32'(0));
                check("rst_rgb",   32'({red, green, blue}), 32'(0));
                check("rst_uf",    32'(underflow),     32'(0));
                check("rst_fs",    32'(frame_start),   32'(0));
                check("rst_ready", 32'(ifc.snk_ready), 32'(0));
            end else if (exp_q.size() == 0) begin
                check("exp_queue", 32'(exp_q.size()), 32'(1));
            end else begin
                mon_e = exp_q.pop_front();
                check("de",          32'(de),               32'(mon_e.de));
                check("vh",          32'(vh),               32'(mon_e.vh));
                check("rgb",         32'({red, green, blue}), 32'(mon_e.rgb));
                check("underflow",   32'(underflow),        32'(mon_e.uf));
                check("frame_start", 32'(frame_start),      32'(mon_e.fs));
                check("snk_ready",   32'(ifc.snk_ready),    32'(mon_e.rdy));
            end
        end
    end

    // Source handshake observation.
    initial begin
        forever begin
            @(negedge clk);
            done = presenting && (src[0].gap || (ifc.snk_valid && ifc.snk_ready));
        end
    end

    // Source driver: plays the item queue; gap items are idle cycles with junk on the bus.
    initial begin
        ifc.snk_valid = 1'b0;
        ifc.snk_data  = '0;
        ifc.snk_sop   = 1'b0;
        ifc.snk_eop   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                presenting    = 1'b0;
                ifc.snk_valid = 1'b0;
            end else begin
                if (presenting && done) begin
                    void'(src.pop_front());
                    presenting = 1'b0;
                end
                if (src.size() > 0) begin
                    presenting    = 1'b1;
                    ifc.snk_valid = !src[0].gap;
                    ifc.snk_data  = src[0].gap ? 24'($urandom) : src[0].data;
                    ifc.snk_sop   = src[0].gap ? 1'($urandom) : src[0].sop;
                    ifc.snk_eop   = src[0].gap ? 1'($urandom) : src[0].eop;
                end else begin
                    ifc.snk_valid = 1'b0;
                end
            end
        end
    end

    // Queue one 8-beat frame; extra_sop/eop_at/gap_before shape framing faults.
    task automatic push_frame(bit seq, int extra_sop, int eop_at, int gap_before, int gap_len);
        for (int i = 0; i < HA * VA; i++) begin
            if (i == gap_before)
                for (int j = 0; j < gap_len; j++)
                    src.push_back('{gap: 1'b1, data: 24'h0, sop: 1'b0, eop: 1'b0});
            src.push_back('{gap: 1'b0,
                            data: seq ? 24'(i + 1) : 24'($urandom),
                            sop: (i == 0) || (i == extra_sop),
                            eop: (i == eop_at)});
        end
    endtask

    task automatic push_good(bit seq);
        push_frame(seq, -1, HA * VA - 1, -1, 0);
    endtask

    task automatic push_junk(int n);
        for (int i = 0; i < n; i++)
            src.push_back('{gap: 1'b0, data: 24'($urandom), sop: 1'b0, eop: 1'($urandom)});
    endtask

    task automatic push_idle(int n);
        for (int i = 0; i < n; i++)
            src.push_back('{gap: 1'b1, data: 24'h0, sop: 1'b0, eop: 1'b0});
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 20000 && src.size() != 0; i++) @(posedge clk);
        check(name, 32'(src.size()), 32'(0));
    endtask

    int kind, e_at, tries;

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Idle raster, then junk ahead of an aligned frame, then directed faults.
        push_idle(2 * FRAME);
        push_junk(3);
        push_good(1'b1);
        push_good(1'b1);
        push_frame(1'b1, -1, HA * VA - 1, 5, 2);
        push_good(1'b0);
        push_good(1'b0);
        push_frame(1'b0, 2, HA * VA - 1, -1, 0);
        push_good(1'b0);
        push_good(1'b0);
        wait_drain("drain_directed");

        // Random episodes.
        for (int ep = 0; ep < 40; ep++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: push_good(1'b0);
                2:    push_frame(1'b0, -1, HA * VA - 1, $urandom_range(1, 7), $urandom_range(1, 3));
                3:    push_frame(1'b0, $urandom_range(1, 7), HA * VA - 1, -1, 0);
                4: begin
                    e_at = $urandom_range(0, 7);
                    push_frame(1'b0, -1, (e_at == 7) ? -1 : e_at, -1, 0);
                end
                default: begin
                    push_junk($urandom_range(1, 4));
                    push_idle($urandom_range(1, 6));
                end
            endcase
        end
        wait_drain("drain_random");

        // Reset while the 3rd active pixel is on the outputs.
        for (int i = 0; i < 4; i++) push_good(1'b0);
        for (int i = 0; i < 20000 && src.size() > 2 * HA * VA; i++) @(posedge clk);
        tries = 0;
        @(posedge clk);
        #2;
        while ((k % FRAME) != 3 && tries < 200) begin
            @(posedge clk);
            #2;
            tries++;
        end
        check("reset_pos_found", 32'(k % FRAME), 32'(3));
        reset_n = 1'b0;
        #1;
        check("async_rst_de",    32'(de),                 32'(0));
        check("async_rst_vh",    32'(vh),                 32'(0));
        check("async_rst_rgb",   32'({red, green, blue}), 32'(0));
        check("async_rst_ready", 32'(ifc.snk_ready),      32'(0));
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        #1 check("ready_first_cycle", 32'(ifc.snk_ready), 32'(0));
        @(posedge clk);
        #2 check("ready_second_cycle", 32'(ifc.snk_ready), 32'(1));

        src.delete();
        push_good(1'b0);
        push_good(1'b0);
        wait_drain("drain_recovery");
        repeat (3 * FRAME) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Upstream neighbour of the TMDS encoders in the HDMI Avalon-ST IP.
- Sinks a 24-bit RGB Avalon-ST pixel stream with frame-marking `startofpacket`/`endofpacket`.
- Generates raster timing and drives `de`, `vh = {vsync, hsync}` and per-channel 8-bit colour, registered, one set per pixel clock.
- Aligns stream frames to the raster and recovers from underflow or misframing by re-seeking `startofpacket`.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level

Ports:
- clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- snk_data  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- snk_valid  in  1  beat valid
- snk_sop  in  1  first pixel of frame
- snk_eop  in  1  last pixel of frame
- snk_ready  out  1  beat accepted when snk_valid && snk_ready; ready latency 0
- de  out  1  data enable to encoders
- vh  out  2  {vsync, hsync}, polarity applied
- red  out  8  channel-2 colour
- green  out  8  channel-1 colour
- blue  out  8  channel-0 colour
- underflow  out  1  one-cycle pulse per starved or misframed frame
- frame_start  out  1  one-cycle pulse coincident with first active `de` of each frame

Behaviour:
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0, state=SEEK, pix_vld=0.
  - de=0, colour=0, vh={~VS_POL,~HS_POL}, underflow=0, frame_start=0.
  - snk_ready=0 while reset_n=0 and for the first cycle after release (gated by a registered enable).
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), then wraps.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - Line order is active, FP, sync, BP. Vertical order is the same.
  - Counters run free from reset and are independent of stream state.
- Outputs, registered, 1-cycle latency from counters:
  - act = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vsync switches at h_cnt==0.
  - de<=act; vh<={vs?VS_POL:~VS_POL, hs?HS_POL:~HS_POL}; colour=0 whenever act=0.
- Holding register: pix_q/pix_vld, one 24-bit word plus sop/eop flags.
  - Fills whenever empty, or in the same cycle it drains.
  - snk_ready = en && (!pix_vld || drain); drain = (state==RUN) && act.
- FSM:
  - SEEK: snk_ready=1 (enabled). Beats without sop are discarded. A beat with sop is captured into pix_q, then go to ARMED.
  - ARMED: hold pix_q. At h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1, go to RUN.
  - RUN: on each act cycle, colour<=pix_q and pix_q is consumed. frame_start pulses on (0,0).
- Error handling in RUN:
  - act && !pix_vld: colour=0 for that pixel, underflow pulse, go to SEEK. The remaining frame outputs black while timing continues.
  - Consumed word has sop but the pixel is not (0,0), or lacks sop at (0,0): underflow pulse, go to SEEK. This pixel is output black.
  - Consumed eop at a pixel other than the last active pixel, or a missing eop there: same as above.
- Simultaneous events: drain and fill in the same cycle is legal and keeps pix_vld=1. Errors take priority over frame_start.
- Underflow pulses at most once per frame.
- Reset mid-frame returns every register to its reset value immediately.

Decomposition:
- Package `hdmi_pkg`:
  - typedef rgb_t, a packed struct {r, g, b} of 8 bits each.
  - typedef fsm_e {SEEK, ARMED, RUN}.
  - localparam function for H_TOTAL/V_TOTAL.
- One sub-module: `hdmi_raster_cnt`, containing the h/v counters plus the act, hs and vs decode. The top level holds the FSM, holding register and output registers.

Test Plan (small raster: H 4/1/2/1, V 2/1/1/1; H_TOTAL=8, V_TOTAL=5; HS_POL=VS_POL=1):
- Reset released, no stream -> de=0, colour=0; hsync high for h_cnt 5..6 of every line (seen one cycle later); vsync high for the whole of line 3; snk_ready=1 from the 2nd cycle.
- Continuous valid frame, 8 pixels 0x000001..0x000008 with sop on the 1st and eop on the 8th -> first frame black. Next frame: blue=1..4 on line 0 and 5..8 on line 1; frame_start on pixel 1; underflow never asserts.
- Three junk beats without sop precede the frame -> all three accepted and discarded; output aligns as in the previous case.
- In RUN, snk_valid dropped before pixel 6 -> pixel 6 and later are black, one underflow pulse, state SEEK. The next sop frame displays one frame later.
- sop arrives on the 3rd beat of a RUN frame -> underflow pulse, that pixel black, FSM realigns at the next frame boundary.
- reset_n asserted at the 3rd active pixel -> de=0, colour=0, vh={0,0} asynchronously; snk_ready=0 until one cycle after release.
